// File: rtl/mod_reduce_pkg.sv
// Shared encodings and sizing for the modular arithmetic datapath (multiplier and reducer).
package mod_reduce_pkg;

  localparam int DEF_WIDTH = 8;

  // IDLE=0 / CALC=1 encodings are common with the shift-add multiplier
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Bit count for a counter that walks all 2*w dividend bits
  function automatic int cnt_width(input int w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/mod_sub_step.sv
// One restoring-division step: compare t against N and conditionally subtract; purely combinational.
// Both compare and subtract are always evaluated so timing never depends on operand values.
module mod_sub_step
  import mod_reduce_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   t,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] rem_nxt
);

  logic             ge;
  logic [WIDTH-1:0] diff;

  assign ge = (t >= {1'b0, n});
  // When t >= N the true difference is below N < 2^WIDTH, so the low bits are exact
  assign diff    = t[WIDTH-1:0] - n;
  assign rem_nxt = ge ? diff : t[WIDTH-1:0];

endmodule

// File: rtl/mod_reduce.sv
// Sequential product mod N reducer, one dividend bit per cycle; finish 2*WIDTH cycles after start.
// No backpressure: start is taken only in IDLE and ignored while busy; result held until next completion.
module mod_reduce
  import mod_reduce_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   in,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     out,
  output logic                 finish,
  output logic                 busy,
  output logic                 err
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0]   n_reg;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH:0]     t;
  logic               dvd_bit;

  // Dividend consumed MSB first; rem < N keeps the shifted value within WIDTH+1 bits
  assign dvd_bit = dvd_reg[LAST - cnt];
  assign t       = {rem, dvd_bit};

  mod_sub_step #(.WIDTH(WIDTH)) u_step (
    .t       (t),
    .n       (n_reg),
    .rem_nxt (rem_nxt)
  );

  assign busy = (state == CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd_reg <= '0;
      n_reg   <= '0;
      rem     <= '0;
      out     <= '0;
      finish  <= 1'b0;
      err     <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_reg <= in;
            n_reg   <= modulus;
            rem     <= '0;
            cnt     <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          if (cnt == LAST) begin
            // N==0 still runs the full sequence; the result is forced to zero and flagged
            out    <= (n_reg == '0) ? '0 : rem_nxt;
            err    <= (n_reg == '0);
            finish <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce.sv
// Randomized scoreboard bench for mod_reduce: expected remainders come from in % N.
module tb_mod_reduce;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] out;
    logic         err;
    int           acc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [2*W-1:0] din = '0;
  logic [W-1:0]   modulus = '0;
  logic [W-1:0]   out;
  logic           finish;
  logic           busy;
  logic           err;

  mod_reduce #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in      (din),
    .modulus (modulus),
    .out     (out),
    .finish  (finish),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           edge_n = 0;
  int           acc_edge = -100;
  bit           active = 1'b0;
  bit           mon_en = 1'b0;
  logic [W-1:0] held_out = '0;
  logic         held_err = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  // One clock edge; the reference model decides acceptance from the sampled inputs
  task automatic tick();
    exp_t e;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      exp_q.delete();
      active   = 1'b0;
      held_out = '0;
      held_err = 1'b0;
    end else if (start && (!active || edge_n > acc_edge + 2*W)) begin
      e.acc = edge_n;
      if (modulus == 0) begin
        e.out = '0;
        e.err = 1'b1;
      end else begin
        e.out = W'(int'(din) % int'(modulus));
        e.err = 1'b0;
      end
      exp_q.push_back(e);
      active   = 1'b1;
      acc_edge = edge_n;
    end
    #1;
  endtask

  task automatic do_op(input logic [2*W-1:0] a, input logic [W-1:0] n,
                       input logic [W-1:0] exp_out, input logic exp_err, input bit repulse);
    start   = 1'b1;
    din     = a;
    modulus = n;
    tick();
    for (int i = 0; i < 2*W; i++) begin
      start   = repulse && (i == 4);
      din     = 16'($urandom);
      modulus = 8'($urandom);
      tick();
    end
    start = 1'b0;
    check("dir_finish", finish, 1);
    check("dir_out", out, exp_out);
    check("dir_err", err, exp_err);
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("busy", busy, int'(active && edge_n < acc_edge + 2*W));
        check("finish", finish, int'(active && edge_n == acc_edge + 2*W));
        if (finish && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out", out, e.out);
          check("err", err, e.err);
          check("latency", edge_n - e.acc, 2*W);
          held_out = e.out;
          held_err = e.err;
        end else if (!finish) begin
          check("out_hold", out, held_out);
          check("err_hold", err, held_err);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_out", out, 0);
    check("rst_finish", finish, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    tick();

    do_op(16'h1234, 8'h65, 8'h0E, 1'b0, 1'b1);
    do_op(16'hFFFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    do_op(16'h00C8, 8'hFB, 8'hC8, 1'b0, 1'b1);
    do_op(16'hABCD, 8'h00, 8'h00, 1'b1, 1'b0);
    do_op(16'h0064, 8'h07, 8'h02, 1'b0, 1'b0);

    // Reset while the counter sits at 5
    start   = 1'b1;
    din     = 16'h4321;
    modulus = 8'h33;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out", out, 0);
    check("midrst_finish", finish, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    tick();
    do_op(16'h1234, 8'h65, 8'h0E, 1'b0, 1'b0);

    for (int c = 0; c < 30000; c++) begin
      start   = ($urandom_range(0, 3) != 0);
      din     = 16'($urandom);
      modulus = ($urandom_range(0, 19) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rst     = ($urandom_range(0, 4999) == 0);
      tick();
    end
    start = 1'b0;
    rst   = 1'b0;

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
    tick();
    check("drain_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
